// File: rtl/oled_link_arbiter_if.sv
// Requester-side handshake bundle for the OLED link arbiter.
// Requesters drive the master modport; the arbiter consumes the slave modport.
interface oled_link_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_dnc;
  logic        req0_wide;
  logic [15:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_dnc;
  logic        req1_wide;
  logic [15:0] req1_data;
  logic        req1_lock;

  modport master (
    output req0_valid, req0_dnc, req0_wide, req0_data,
    output req1_valid, req1_dnc, req1_wide, req1_data, req1_lock,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_dnc, req0_wide, req0_data,
    input  req1_valid, req1_dnc, req1_wide, req1_data, req1_lock,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/oled_link_arbiter.sv
// Shares one OLED serial link between a CPU requester (priority) and a refresh
// streamer that may hold the link for a bounded burst of locked packages.
module oled_link_arbiter #(
  parameter int CLK_DIV  = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic                HCLK,
  input  logic                HRESET,
  oled_link_arbiter_if.slave  link,
  output logic                busy,
  output logic                owner,
  output logic                nCS,
  output logic                DnC,
  output logic                SDIN,
  output logic                SCLK
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, GAP} state_t;

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  state_t      state;
  logic [15:0] shift;
  logic [4:0]  bit_cnt;
  logic [3:0]  div_cnt;
  logic        dnc_q;
  logic        owner_q;
  logic        lock_flag;
  logic [7:0]  lock_cnt;

  logic        idle;
  logic        lock_expired;
  logic        lock_force;
  logic        grant0;
  logic        grant1;
  logic        sel_dnc;
  logic        sel_wide;
  logic [15:0] sel_data;

  // An expired lock stops forcing requester 1 so a waiting requester 0 gets one slot.
  always_comb begin
    idle         = (state == IDLE) && !HRESET;
    lock_expired = lock_flag && (lock_cnt >= LOCK_LIMIT);
    lock_force   = lock_flag && !lock_expired;
    grant0       = idle && !lock_force && link.req0_valid;
    grant1       = idle && link.req1_valid && (lock_force || !link.req0_valid);
    sel_dnc      = grant1 ? link.req1_dnc  : link.req0_dnc;
    sel_wide     = grant1 ? link.req1_wide : link.req0_wide;
    sel_data     = grant1 ? link.req1_data : link.req0_data;
  end

  assign link.req0_ready = grant0;
  assign link.req1_ready = grant1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      dnc_q     <= 1'b0;
      owner_q   <= 1'b0;
      lock_flag <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_expired) begin
            lock_flag <= 1'b0;
            lock_cnt  <= '0;
          end
          if (grant0 || grant1) begin
            shift   <= sel_wide ? sel_data : {sel_data[7:0], 8'h00};
            bit_cnt <= sel_wide ? 5'd16 : 5'd8;
            dnc_q   <= sel_dnc;
            owner_q <= grant1;
            div_cnt <= DIV_LAST;
            state   <= SETUP;
            if (grant1) begin
              lock_flag <= link.req1_lock;
              if (!link.req1_lock)
                lock_cnt <= '0;
              else if (lock_expired)
                lock_cnt <= 8'd1;
              else
                lock_cnt <= lock_cnt + 8'd1;
            end else begin
              lock_cnt <= '0;
            end
          end
        end
        SETUP: begin
          if (div_cnt == 4'd0) begin
            div_cnt <= DIV_LAST;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt - 4'd1;
          end
        end
        HIGH: begin
          if (div_cnt == 4'd0) begin
            shift   <= {shift[14:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
            div_cnt <= DIV_LAST;
            state   <= (bit_cnt == 5'd1) ? GAP : SETUP;
          end else begin
            div_cnt <= div_cnt - 4'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pads decode only from registered state so the link never glitches on input changes.
  assign busy  = (state != IDLE);
  assign owner = owner_q;
  assign nCS   = !((state == SETUP) || (state == HIGH));
  assign SCLK  = (state == HIGH);
  assign SDIN  = ((state == SETUP) || (state == HIGH)) && shift[15];
  assign DnC   = dnc_q;

endmodule

// File: tb/tb_oled_link_arbiter.sv
// Scoreboard bench for oled_link_arbiter: a transaction-level arbitration model
// predicts grants and packages; a pin monitor decodes the serial link and compares.
module tb_oled_link_arbiter;
  localparam int CLK_DIV  = 1;
  localparam int LOCK_MAX = 4;

  typedef struct {
    logic        dnc;
    logic        wide;
    logic [15:0] data;
    logic        lock;
  } pkg_t;

  typedef struct {
    int          bits;
    logic [15:0] value;
    logic        dnc;
    logic        owner;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;
  logic busy, owner, nCS, DnC, SDIN, SCLK;

  oled_link_arbiter_if link();

  oled_link_arbiter #(.CLK_DIV(CLK_DIV), .LOCK_MAX(LOCK_MAX)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .link(link),
    .busy(busy), .owner(owner), .nCS(nCS), .DnC(DnC), .SDIN(SDIN), .SCLK(SCLK)
  );

  always #5 HCLK = ~HCLK;

  pkg_t q0[$], q1[$];
  exp_t expq[$];
  bit   owner_log[$];
  int   accept_log[$];
  bit   en0, en1, rand_gate;
  int   vectors = 0, miscompares = 0;
  int   cyc, grants;
  int   m_busy, m_cnt;
  bit   m_flag, m_owner;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One HCLK cycle: drive requester heads, then predict and check the arbitration outcome.
  task automatic applyStimulus();
    bit   v0, v1, locked;
    int   winner;
    pkg_t p;
    exp_t e;
    @(posedge HCLK);
    #1;
    v0 = en0 && (q0.size() > 0) && (!rand_gate || $urandom_range(0, 3) != 0);
    v1 = en1 && (q1.size() > 0) && (!rand_gate || $urandom_range(0, 3) != 0);
    link.req0_valid = v0;
    link.req0_dnc   = v0 ? q0[0].dnc  : 1'($urandom);
    link.req0_wide  = v0 ? q0[0].wide : 1'($urandom);
    link.req0_data  = v0 ? q0[0].data : 16'($urandom);
    link.req1_valid = v1;
    link.req1_dnc   = v1 ? q1[0].dnc  : 1'($urandom);
    link.req1_wide  = v1 ? q1[0].wide : 1'($urandom);
    link.req1_data  = v1 ? q1[0].data : 16'($urandom);
    link.req1_lock  = v1 ? q1[0].lock : 1'($urandom);
    @(negedge HCLK);
    cyc++;
    winner = -1;
    if (m_busy == 0) begin
      locked = m_flag && (m_cnt < LOCK_MAX);
      if (locked)  winner = v1 ? 1 : -1;
      else if (v0) winner = 0;
      else if (v1) winner = 1;
    end
    checkOutput("req0_ready", link.req0_ready, winner == 0);
    checkOutput("req1_ready", link.req1_ready, winner == 1);
    checkOutput("busy", busy, m_busy > 0);
    checkOutput("owner_out", owner, m_owner);
    if ((link.req0_ready && v0) || (link.req1_ready && v1)) accept_log.push_back(cyc);
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (m_flag && m_cnt >= LOCK_MAX) begin
        m_flag = 0;
        m_cnt  = 0;
      end
      if (winner >= 0) begin
        if (winner == 0) begin
          p = q0.pop_front();
          m_cnt = 0;
        end else begin
          p = q1.pop_front();
          if (p.lock) begin
            m_flag = 1;
            m_cnt++;
          end else begin
            m_flag = 0;
            m_cnt  = 0;
          end
        end
        m_owner = (winner == 1);
        e.bits  = p.wide ? 16 : 8;
        e.value = p.wide ? p.data : {8'h00, p.data[7:0]};
        e.dnc   = p.dnc;
        e.owner = m_owner;
        expq.push_back(e);
        m_busy = 2 * e.bits * CLK_DIV + 1;
        grants++;
      end
    end
  endtask

  task automatic runUntilDrained(input string name, input int maxCycles);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy > 0 || expq.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_drain_timeout"},
                (q0.size() > 0 || q1.size() > 0 || m_busy > 0 || expq.size() > 0), 0);
  endtask

  task automatic waitGrant(input string name);
    int g = grants;
    int n = 0;
    while (grants == g && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_grant_timeout"}, grants == g, 0);
  endtask

  task automatic checkOwnerLog(input string name, input int len, input logic [15:0] pat);
    checkOutput({name, "_pkg_count"}, owner_log.size(), len);
    for (int i = 0; i < len && i < owner_log.size(); i++)
      checkOutput($sformatf("%s_owner%0d", name, i), owner_log[i], pat[i]);
  endtask

  // Pin monitor: decode each nCS-low window and compare it with the scoreboard head.
  initial begin : monitor
    bit          active;
    int          rises, lowc;
    logic [15:0] cap;
    logic        prev_sclk;
    exp_t        e;
    active = 0;
    prev_sclk = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        active = 0;
        prev_sclk = 0;
      end else if (!nCS) begin
        if (!active) begin
          active = 1;
          rises = 0;
          lowc = 0;
          cap = '0;
          prev_sclk = 0;
          if (expq.size() == 0) begin
            checkOutput("unexpected_package", 1, 0);
            e = '{bits: 0, value: 16'h0, dnc: 1'b0, owner: 1'b0};
          end else begin
            e = expq[0];
          end
        end
        lowc++;
        if (SCLK && !prev_sclk) begin
          rises++;
          cap = {cap[14:0], SDIN};
        end
        prev_sclk = SCLK;
        checkOutput("dnc_pin", DnC, e.dnc);
        checkOutput("owner_busy", owner, e.owner);
      end else if (active) begin
        active = 0;
        checkOutput("gap_sclk", SCLK, 0);
        checkOutput("gap_dnc", DnC, e.dnc);
        checkOutput("sclk_rises", rises, e.bits);
        checkOutput("payload", cap, e.value);
        checkOutput("ncs_low_cycles", lowc, 2 * e.bits * CLK_DIV);
        owner_log.push_back(e.owner);
        if (expq.size() > 0) void'(expq.pop_front());
      end
    end
  end

  initial begin : stimulus
    pkg_t p;
    en0 = 1; en1 = 1; rand_gate = 0;
    cyc = 0; grants = 0; m_busy = 0; m_cnt = 0; m_flag = 0; m_owner = 0;
    HRESET = 1'b1;
    link.req0_valid = 1'b1; link.req0_dnc = 1'b1; link.req0_wide = 1'b1; link.req0_data = 16'hFFFF;
    link.req1_valid = 1'b1; link.req1_dnc = 1'b1; link.req1_wide = 1'b1; link.req1_data = 16'hFFFF;
    link.req1_lock  = 1'b1;
    #3;
    checkOutput("rst_ready0", link.req0_ready, 0);
    checkOutput("rst_ready1", link.req1_ready, 0);
    checkOutput("rst_ncs", nCS, 1);
    checkOutput("rst_sclk", SCLK, 0);
    checkOutput("rst_sdin", SDIN, 0);
    checkOutput("rst_dnc", DnC, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    link.req0_valid = 1'b0;
    link.req1_valid = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;

    // Two narrow CPU packages back to back: accept-to-accept must be 18 cycles.
    accept_log.delete(); owner_log.delete();
    q0.push_back('{dnc: 1'b1, wide: 1'b0, data: 16'h00A5, lock: 1'b0});
    q0.push_back('{dnc: 1'b1, wide: 1'b0, data: 16'h123C, lock: 1'b0});
    runUntilDrained("p1", 200);
    checkOutput("p1_accepts", accept_log.size(), 2);
    if (accept_log.size() >= 2)
      checkOutput("p1_accept_spacing", accept_log[1] - accept_log[0], 18);

    // Wide streamer package with a single leading and trailing one.
    owner_log.delete();
    q1.push_back('{dnc: 1'b0, wide: 1'b1, data: 16'h8001, lock: 1'b0});
    runUntilDrained("p2", 200);
    checkOwnerLog("p2", 1, 16'h0001);

    // Simultaneous requests without lock: CPU first.
    owner_log.delete();
    q1.push_back('{dnc: 1'b1, wide: 1'b1, data: 16'h5AC3, lock: 1'b0});
    q0.push_back('{dnc: 1'b0, wide: 1'b0, data: 16'h0096, lock: 1'b0});
    runUntilDrained("p3", 200);
    checkOwnerLog("p3", 2, 16'h0002);

    // Locked burst with CPU waiting: four streamer packages, one CPU slot, streamer resumes.
    owner_log.delete();
    en0 = 0;
    for (int i = 0; i < 6; i++)
      q1.push_back('{dnc: 1'b1, wide: 1'($urandom), data: 16'($urandom), lock: (i != 5)});
    waitGrant("p4");
    en0 = 1;
    q0.push_back('{dnc: 1'b0, wide: 1'b1, data: 16'hBEEF, lock: 1'b0});
    runUntilDrained("p4", 1000);
    checkOwnerLog("p4", 7, 16'h006F);

    // Lock held while the streamer goes quiet: CPU stays blocked until an unlocking package.
    owner_log.delete(); accept_log.delete();
    en0 = 0;
    q1.push_back('{dnc: 1'b1, wide: 1'b0, data: 16'h0033, lock: 1'b1});
    waitGrant("p5");
    en0 = 1;
    q0.push_back('{dnc: 1'b0, wide: 1'b0, data: 16'h00C9, lock: 1'b0});
    repeat (27) applyStimulus();
    checkOutput("p5_locked_accepts", accept_log.size(), 1);
    q1.push_back('{dnc: 1'b0, wide: 1'b1, data: 16'h7E81, lock: 1'b0});
    runUntilDrained("p5", 200);
    checkOwnerLog("p5", 3, 16'h0003);

    // Reset at the fifth SCLK rise of a locked wide streamer package.
    q1.push_back('{dnc: 1'b1, wide: 1'b1, data: 16'hC3A5, lock: 1'b1});
    waitGrant("p6");
    repeat (9) applyStimulus();
    @(posedge HCLK);
    #2;
    checkOutput("p6_sclk_before_reset", SCLK, 1);
    HRESET = 1'b1;
    expq.delete();
    m_busy = 0; m_cnt = 0; m_flag = 0; m_owner = 0;
    link.req0_valid = 1'b0;
    link.req1_valid = 1'b0;
    #1;
    checkOutput("p6_ncs", nCS, 1);
    checkOutput("p6_sclk", SCLK, 0);
    checkOutput("p6_busy", busy, 0);
    checkOutput("p6_owner", owner, 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    owner_log.delete();
    q1.push_back('{dnc: 1'b0, wide: 1'b1, data: 16'hA55A, lock: 1'b0});
    q0.push_back('{dnc: 1'b1, wide: 1'b1, data: 16'h0FF0, lock: 1'b0});
    runUntilDrained("p6", 200);
    checkOwnerLog("p6", 2, 16'h0002);

    // Random traffic with random valid gaps and random locks.
    rand_gate = 1;
    for (int i = 0; i < 40; i++) begin
      p.dnc  = 1'($urandom);
      p.wide = 1'($urandom);
      p.data = 16'($urandom);
      p.lock = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        p.lock = 1'($urandom);
        q1.push_back(p);
      end else begin
        q0.push_back(p);
      end
    end
    q1.push_back('{dnc: 1'b1, wide: 1'b0, data: 16'h0042, lock: 1'b0});
    runUntilDrained("p7", 6000);
    rand_gate = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oled_link_arbiter.md
Name: oled_link_arbiter

Overview:
- Shares the single OLED serial link (nCS/DnC/SDIN/SCLK) between two requesters.
  - Requester 0: CPU-side command/data path, high priority.
  - Requester 1: hardware display-refresh streamer, which may lock the link for a pixel burst.
- Each accepted transfer is one 8- or 16-bit package, shifted MSB-first with the same two-phase SCLK framing the SoC already uses for the OLED.
- Sits between the bus-facing OLED registers / refresh engine and the chip pads.

Parameters:
- CLK_DIV, 1, HCLK cycles per SCLK phase (low and high each); legal range 1..15.
- LOCK_MAX, 64, max consecutive locked requester-1 grants before one requester-0 slot is forced; legal range 1..255.

Ports:
- HCLK  in  1  system clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a package
- req0_ready  out  1  requester 0 package accepted this cycle when valid&ready
- req0_dnc  in  1  DnC level for the package (1 = data, 0 = command)
- req0_wide  in  1  1 = send 16 bits, 0 = send data[7:0] only
- req0_data  in  16  package payload
- req1_valid  in  1  as req0
- req1_ready  out  1  as req0
- req1_dnc  in  1  as req0
- req1_wide  in  1  as req0
- req1_data  in  16  as req0
- req1_lock  in  1  sampled at acceptance; 1 = keep link for requester 1's next package
- busy  out  1  1 whenever state != IDLE
- owner  out  1  requester index of the current or last accepted package
- nCS  out  1  OLED chip select, active low
- DnC  out  1  OLED data/command
- SDIN  out  1  OLED serial data
- SCLK  out  1  OLED serial clock

Behaviour:
- Reset (async, HRESET=1):
  - state=IDLE; nCS=1, SCLK=0, SDIN=0, DnC=0, busy=0, owner=0.
  - req0_ready=0, req1_ready=0; lock flag=0, lock counter=0.
- States: IDLE, SETUP, HIGH, GAP. Pad outputs decode from registered state/shift register only (no combinational path from inputs).
- IDLE arbitration:
  - reqN_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Grant to requester 1 if lock flag=1 and lock counter<LOCK_MAX.
  - Otherwise grant to requester 0 if req0_valid=1.
  - Otherwise grant to requester 1 if req1_valid=1.
  - Locked and req1_valid=0: stay IDLE, req0 is still blocked. Lock holds until requester 1 presents a package with req1_lock=0, or the counter reaches LOCK_MAX.
  - At counter==LOCK_MAX: requester 0 gets the next grant if valid. The lock flag clears and the counter resets either way.
- Accept (valid&ready in IDLE):
  - Capture data into the shift register; left-justify when wide=0 (data[7:0] into bits 15:8).
  - Capture bit count (16 or 8), DnC level and owner.
  - If owner=1: lock flag <= req1_lock; counter increments when locked.
  - If owner=0: lock counter clears.
  - Next state is SETUP.
- SETUP: nCS=0, SCLK=0, SDIN=shift[15], held CLK_DIV cycles, then HIGH.
- HIGH: nCS=0, SCLK=1, held CLK_DIV cycles.
  - On exit, shift left by 1 and decrement the bit count.
  - Next state is SETUP if count>0, else GAP.
- GAP: nCS=1, SCLK=0, exactly 1 cycle, then IDLE. The earliest next acceptance is the cycle after GAP.
- DnC is stable from the cycle after accept until the end of GAP, and holds its last value in IDLE.
- Timing: a package occupies 1 (accept) + 2·bits·CLK_DIV + 1 (GAP) cycles, accept-to-accept.
  - 8 bits at CLK_DIV=1: 18 cycles.
- Inputs changing while busy are ignored. Back-to-back valid from both requesters with no lock serves req0 every time; req1 only gets the link when req0_valid=0.
- Reset mid-transfer: immediate abort to reset values. nCS rises asynchronously; no partial package resumes.
- CLK_DIV=1 must yield SCLK at HCLK/2 with no skipped phases.

Test Plan:
- req0: valid, dnc=1, wide=0, data=0x00A5; CLK_DIV=1 -> nCS low 16 cycles, 8 SCLK rises, SDIN at rises = 1,0,1,0,0,1,0,1, DnC=1; next req0_ready 18 cycles after accept.
- req1: dnc=0, wide=1, data=0x8001 -> 16 rises, SDIN 1 then fourteen 0s then 1, DnC=0; owner=1, busy=1 throughout.
- Both valid in the same IDLE cycle, no lock -> req0 accepted first, req1 next; two packages separated by one GAP cycle with nCS=1.
- req1 streams with lock=1, req0 held valid, LOCK_MAX=4 -> exactly 4 req1 packages, then one req0 package, then req1 resumes.
- req1 lock=1 then req1_valid drops for 10 cycles -> link idle, req0_ready stays 0; req1 returns with lock=0 -> it is accepted and req0 is served after it.
- HRESET pulsed at the 5th SCLK rise of a 16-bit package -> nCS=1, SCLK=0, busy=0 immediately; after release, the first package is sent completely with correct bits.
